// File: rtl/run_bounds.sv
// Scans captured X then Y occupancy vectors one bit per clock and records up to
// MAX_RUNS qualifying runs per axis as offset, saturated start/end coordinates.
module run_bounds #(
    parameter int WIDTH    = 480,
    parameter int HEIGHT   = 480,
    parameter int COORD_W  = 9,
    parameter int MAX_RUNS = 2,
    parameter int MIN_RUN  = 1,
    parameter int OFFSET   = 10,
    localparam int CNT_W   = $clog2(MAX_RUNS + 1)
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [WIDTH-1:0]   horz_patterns,
    input  logic [HEIGHT-1:0]  vert_patterns,
    input  logic               start_in,
    output logic               busy_out,
    output logic               valid_out,
    output logic [COORD_W-1:0] x_start_out [MAX_RUNS],
    output logic [COORD_W-1:0] x_end_out   [MAX_RUNS],
    output logic [COORD_W-1:0] y_start_out [MAX_RUNS],
    output logic [COORD_W-1:0] y_end_out   [MAX_RUNS],
    output logic [CNT_W-1:0]   x_count_out,
    output logic [CNT_W-1:0]   y_count_out,
    output logic               x_overflow_out,
    output logic               y_overflow_out
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN_X, S_SCAN_Y, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     hsh_q;
    logic [HEIGHT-1:0]    vsh_q;
    logic [COORD_W-1:0]   index_q;
    logic [COORD_W-1:0]   run_start_q;
    logic                 in_run_q;
    logic                 busy_q, valid_q;
    logic [COORD_W-1:0]   xs_q [MAX_RUNS];
    logic [COORD_W-1:0]   xe_q [MAX_RUNS];
    logic [COORD_W-1:0]   ys_q [MAX_RUNS];
    logic [COORD_W-1:0]   ye_q [MAX_RUNS];
    logic [CNT_W-1:0]     xcnt_q, ycnt_q;
    logic                 xovf_q, yovf_q;

    logic                 scan_x, scanning, cur_bit, is_last;
    logic [COORD_W-1:0]   last_idx;
    logic                 end_vld, rec_vld;
    logic [COORD_W-1:0]   end_start, end_stop;
    logic [COORD_W:0]     run_len;

    // Sum is one bit wider than a coordinate so overflow is visible and clamps.
    function automatic logic [COORD_W-1:0] add_off(input logic [COORD_W-1:0] c);
        logic [COORD_W:0] sum;
        sum = {1'b0, c} + (COORD_W+1)'(OFFSET);
        if (sum[COORD_W]) add_off = '1;
        else              add_off = sum[COORD_W-1:0];
    endfunction

    always_comb begin
        scan_x    = (state_q == S_SCAN_X);
        scanning  = (state_q == S_SCAN_X) || (state_q == S_SCAN_Y);
        cur_bit   = scan_x ? hsh_q[0] : vsh_q[0];
        last_idx  = scan_x ? COORD_W'(WIDTH - 1) : COORD_W'(HEIGHT - 1);
        is_last   = (index_q == last_idx);
        end_vld   = 1'b0;
        end_start = run_start_q;
        end_stop  = index_q;
        if (scanning) begin
            if (cur_bit && is_last) begin
                end_vld = 1'b1;
                if (!in_run_q) end_start = index_q;
            end else if (!cur_bit && in_run_q) begin
                end_vld  = 1'b1;
                end_stop = index_q - 1'b1;
            end
        end
        run_len = {1'b0, end_stop} - {1'b0, end_start} + 1'b1;
        rec_vld = end_vld && (run_len >= (COORD_W+1)'(MIN_RUN));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_in) state_d = S_SCAN_X;
            S_SCAN_X: if (is_last)  state_d = S_SCAN_Y;
            S_SCAN_Y: if (is_last)  state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            hsh_q       <= '0;
            vsh_q       <= '0;
            index_q     <= '0;
            run_start_q <= '0;
            in_run_q    <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            xcnt_q      <= '0;
            ycnt_q      <= '0;
            xovf_q      <= 1'b0;
            yovf_q      <= 1'b0;
            for (int s = 0; s < MAX_RUNS; s++) begin
                xs_q[s] <= '0;
                xe_q[s] <= '0;
                ys_q[s] <= '0;
                ye_q[s] <= '0;
            end
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
            valid_q <= (state_d == S_DONE);

            if (state_q == S_IDLE && start_in) begin
                hsh_q    <= horz_patterns;
                vsh_q    <= vert_patterns;
                index_q  <= '0;
                in_run_q <= 1'b0;
                xcnt_q   <= '0;
                ycnt_q   <= '0;
                xovf_q   <= 1'b0;
                yovf_q   <= 1'b0;
                for (int s = 0; s < MAX_RUNS; s++) begin
                    xs_q[s] <= '0;
                    xe_q[s] <= '0;
                    ys_q[s] <= '0;
                    ye_q[s] <= '0;
                end
            end

            if (scanning) begin
                // The active vector shifts right so bit 0 is always the current index.
                if (scan_x) hsh_q <= hsh_q >> 1;
                else        vsh_q <= vsh_q >> 1;

                if (is_last) begin
                    index_q  <= '0;
                    in_run_q <= 1'b0;
                end else begin
                    index_q <= index_q + 1'b1;
                    if (cur_bit && !in_run_q) begin
                        in_run_q    <= 1'b1;
                        run_start_q <= index_q;
                    end else if (!cur_bit) begin
                        in_run_q <= 1'b0;
                    end
                end

                if (rec_vld && scan_x) begin
                    if (xcnt_q == CNT_W'(MAX_RUNS)) begin
                        xovf_q <= 1'b1;
                    end else begin
                        for (int s = 0; s < MAX_RUNS; s++) begin
                            if (xcnt_q == CNT_W'(s)) begin
                                xs_q[s] <= add_off(end_start);
                                xe_q[s] <= add_off(end_stop);
                            end
                        end
                        xcnt_q <= xcnt_q + 1'b1;
                    end
                end
                if (rec_vld && !scan_x) begin
                    if (ycnt_q == CNT_W'(MAX_RUNS)) begin
                        yovf_q <= 1'b1;
                    end else begin
                        for (int s = 0; s < MAX_RUNS; s++) begin
                            if (ycnt_q == CNT_W'(s)) begin
                                ys_q[s] <= add_off(end_start);
                                ye_q[s] <= add_off(end_stop);
                            end
                        end
                        ycnt_q <= ycnt_q + 1'b1;
                    end
                end
            end
        end
    end

    assign busy_out       = busy_q;
    assign valid_out      = valid_q;
    assign x_start_out    = xs_q;
    assign x_end_out      = xe_q;
    assign y_start_out    = ys_q;
    assign y_end_out      = ye_q;
    assign x_count_out    = xcnt_q;
    assign y_count_out    = ycnt_q;
    assign x_overflow_out = xovf_q;
    assign y_overflow_out = yovf_q;

endmodule

// File: doc/run_bounds.md
# run_bounds

Parametrised successor to the QR finder-pattern bounding stage. It scans one horizontal and one vertical finder-pattern occupancy vector, one bit per clock. For each axis it reports up to MAX_RUNS runs of set bits as start/end coordinates, offset by OFFSET. Runs shorter than MIN_RUN are dropped, and overflow is flagged. It sits between the pattern-detection stage and the perspective/crop stage, and uses a start/busy/valid handshake.

## Interface
- WIDTH, 480: length of horz_patterns; number of X positions scanned.
- HEIGHT, 480: length of vert_patterns; number of Y positions scanned.
- COORD_W, 9: width of every coordinate output and internal index.
- MAX_RUNS, 2: run slots per axis (≥1).
- MIN_RUN, 1: minimum run length in bits for a run to be recorded (≥1).
- OFFSET, 10: constant added to every reported coordinate.
- clk_in  input  1  sole clock; all logic on posedge.
- rst_in  input  1  reset, synchronous, active-high.
- horz_patterns  input  WIDTH  X occupancy vector; bit i = position i.
- vert_patterns  input  HEIGHT  Y occupancy vector.
- start_in  input  1  start request; honoured only in IDLE.
- busy_out  output  1  high while a scan is in progress, including the DONE cycle.
- valid_out  output  1  one-cycle pulse; results are final.
- x_start_out / x_end_out  output  MAX_RUNS×COORD_W  unpacked arrays, per-slot first/last set index + OFFSET.
- y_start_out / y_end_out  output  MAX_RUNS×COORD_W  same for Y.
- x_count_out / y_count_out  output  $clog2(MAX_RUNS+1)  runs recorded.
- x_overflow_out / y_overflow_out  output  1  a qualifying run was found with all slots full.

## Operation
- States: IDLE → SCAN_X → SCAN_Y → DONE → IDLE.
- **IDLE.** When start_in=1:
  - capture both vectors into internal registers, so the inputs may change afterwards;
  - clear all result outputs, counts and overflow flags;
  - set index=0 and in_run=0;
  - go to SCAN_X.
- **SCAN_X.** Each cycle examines captured bit[index].
  - Bit=1 and in_run=0: run_start=index, in_run=1.
  - Bit=0 and in_run=1: the run ends at index-1, length=index-run_start.
  - Bit=1 on the final index (WIDTH-1) with in_run=1: the run ends at WIDTH-1, length=WIDTH-run_start. A run starting on the final bit has length 1.
  - A run that ends is recorded only if length≥MIN_RUN:
    - slot[count] ← (run_start+OFFSET, run_end+OFFSET);
    - count increments;
    - if count==MAX_RUNS already, nothing is stored and overflow is set instead.
  - After index WIDTH-1: reset index and in_run, go to SCAN_Y.
- **SCAN_Y.** Identical to SCAN_X over vert_patterns and HEIGHT, writing the Y outputs. Afterwards go to DONE.
- **DONE.** valid_out=1 for exactly this cycle, then IDLE.
- **Arithmetic.**
  - Coordinate+OFFSET is computed at COORD_W+1 bits.
  - If the sum exceeds 2^COORD_W−1 it saturates to 2^COORD_W−1; it never wraps.
  - Run length is computed at COORD_W+1 bits.
- **Boundary cases.**
  - start_in while busy is ignored, with no restart.
  - An all-zero vector gives count=0, slots=0 and overflow=0.
  - An all-ones vector gives a single run 0..N-1.
  - Outputs hold their values from DONE until the next accepted start.
- **Reset, including mid-scan.** Return to IDLE. All outputs, counts, flags and slots go to 0, and busy_out=0. No valid_out pulse occurs for the aborted scan.

## Timing
- Start sampled in IDLE at cycle T.
- SCAN_X occupies cycles T+1..T+WIDTH.
- SCAN_Y occupies cycles T+WIDTH+1..T+WIDTH+HEIGHT.
- DONE, with valid_out=1, is cycle T+WIDTH+HEIGHT+1.
- Latency from start to valid is WIDTH+HEIGHT+1 cycles (961 at defaults).
- busy_out is high from T+1 through T+WIDTH+HEIGHT+1 inclusive.
- A new start is accepted at T+WIDTH+HEIGHT+2 at the earliest.
- A slot write becomes visible on the outputs the cycle after the run ends.
- valid_out and busy_out are registered outputs.

## Test plan
All scenarios use WIDTH=HEIGHT=16, MAX_RUNS=2, MIN_RUN=2, OFFSET=10, COORD_W=9 unless stated.

- **Basic runs.** horz bits 3–5 and 9–12 set; vert bits 0–1 and 14–15 set; start at T.
  - X: (13,15), (19,22), x_count=2.
  - Y: (10,11), (24,25), y_count=2.
  - valid_out only at T+33; busy_out high T+1..T+33.
- **MIN_RUN filter.** horz bit 7 alone plus bits 2–3.
  - X: x_count=1, slot0=(12,13), slot1=(0,0), x_overflow=0.
- **Overflow.** horz runs 1–2, 5–6 and 9–10.
  - X: slots (11,12) and (15,16); x_count=2; x_overflow=1; y_overflow=0.
- **Edge runs.** horz=0xFFFF → X (10,25), count 1. vert bit 15 only with MIN_RUN=1 → Y (25,25).
- **Saturation.** OFFSET=500 with horz bits 10–11 → X (510,511). With bits 12–13 → X (511,511), no wrap to 0.
- **Control.**
  - Pulse start_in again at T+5: ignored, and valid_out still pulses at T+33.
  - Change inputs after T: results reflect the captured values.
  - Assert rst_in at T+20: all outputs 0, no valid_out pulse, and the next start runs normally.
